// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory front end.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } memState_t;

   localparam int          DEFAULT_TIMEOUT_CYCLES = 15;
   localparam logic [31:0] TIMEOUT_READ_VALUE     = 32'h0;
   localparam logic [1:0]  ALIGN_MASK             = 2'b11;

   function automatic logic isAligned(input logic [1:0] addrLsb);
      return (addrLsb & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/access_timeout_counter.sv
// Counts ACCESS cycles spent waiting for busAck; terminal is high in the last cycle
// allowed before abort. Sized so the count stops one short of wrapping.
module access_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign terminal = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_controller.sv
// Turns single-cycle MemRead/MemWrite into a req/ack bus access, stalling the pipeline
// from request detect until completion; a DONE cycle lets MEM/WB capture readData.
module mem_stage_controller
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writeData,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  stallMem,
   output logic                  busReq,
   output logic                  busWe,
   output logic [ADDR_WIDTH-1:0] busAddr,
   output logic [DATA_WIDTH-1:0] busWData,
   input  logic                  busAck,
   input  logic [DATA_WIDTH-1:0] busRData,
   output logic                  misalignedFault,
   output logic                  timeoutFault
);

   memState_t state, nextState;

   logic access, aligned;
   logic launch, complete, abortNow, setMisaligned;
   logic counterClear, counterEn, counterTerminal;

   assign access  = memRead | memWrite;
   assign aligned = isAligned(address[1:0]);

   access_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) uTimeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (counterClear),
      .enable  (counterEn),
      .terminal(counterTerminal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState     = state;
      launch        = 1'b0;
      complete      = 1'b0;
      abortNow      = 1'b0;
      setMisaligned = 1'b0;
      counterClear  = 1'b0;
      counterEn     = 1'b0;
      stallMem      = 1'b0;
      case (state)
         IDLE: begin
            if (access && aligned) begin
               launch       = 1'b1;
               counterClear = 1'b1;
               stallMem     = 1'b1;
               nextState    = ACCESS;
            end else if (access) begin
               setMisaligned = 1'b1;
            end
         end
         ACCESS: begin
            stallMem = 1'b1;
            // An ack in the terminal cycle still completes normally.
            if (busAck) begin
               complete  = 1'b1;
               nextState = DONE;
            end else if (counterTerminal) begin
               abortNow  = 1'b1;
               nextState = DONE;
            end else begin
               counterEn = 1'b1;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign busReq = (state == ACCESS);

   always_ff @(posedge clk) begin
      if (reset) begin
         readData        <= '0;
         busWe           <= 1'b0;
         busAddr         <= '0;
         busWData        <= '0;
         misalignedFault <= 1'b0;
         timeoutFault    <= 1'b0;
      end else begin
         if (launch) begin
            busAddr  <= {address[ADDR_WIDTH-1:2], 2'b00};
            busWData <= writeData;
            busWe    <= memWrite;
         end
         if (setMisaligned) begin
            misalignedFault <= 1'b1;
         end
         if (complete && !busWe) begin
            readData <= busRData;
         end
         if (abortNow) begin
            timeoutFault <= 1'b1;
            if (!busWe) begin
               readData <= DATA_WIDTH'(TIMEOUT_READ_VALUE);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed-vector bench for mem_stage_controller with hand-computed expectations.
module tb_mem_stage_controller;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          memRead, memWrite, busAck;
   logic [AW-1:0] address, busAddr;
   logic [DW-1:0] writeData, readData, busWData, busRData;
   logic          stallMem, busReq, busWe, misalignedFault, timeoutFault;

   int nChecks = 0;
   int nPass   = 0;
   int cyc     = 0;

   mem_stage_controller #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .memRead        (memRead),
      .memWrite       (memWrite),
      .address        (address),
      .writeData      (writeData),
      .readData       (readData),
      .stallMem       (stallMem),
      .busReq         (busReq),
      .busWe          (busWe),
      .busAddr        (busAddr),
      .busWData       (busWData),
      .busAck         (busAck),
      .busRData       (busRData),
      .misalignedFault(misalignedFault),
      .timeoutFault   (timeoutFault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Holds the request until the DUT leaves ACCESS; acks on ACCESS cycle ackAt (-1 = never).
   task automatic runAccess(
      input  logic          rd,
      input  logic          wr,
      input  logic [AW-1:0] addr,
      input  logic [DW-1:0] wd,
      input  logic [DW-1:0] rdDat,
      input  int            ackAt,
      output int            stallCnt,
      output int            reqCnt,
      output int            firstReqCyc,
      output int            lastReqCyc,
      output logic          stable,
      output logic          weSeen,
      output logic [AW-1:0] addrSeen,
      output logic [DW-1:0] wdSeen,
      output logic [DW-1:0] doneData,
      output logic          doneSeen,
      output logic          doneStall
   );
      memRead = rd; memWrite = wr; address = addr; writeData = wd;
      busAck = 1'b0; busRData = ~rdDat;
      stallCnt = 0; reqCnt = 0; firstReqCyc = 0; lastReqCyc = 0;
      stable = 1'b1; weSeen = 1'b0; addrSeen = '0; wdSeen = '0;
      doneData = '0; doneSeen = 1'b0; doneStall = 1'b1;
      for (int i = 0; i < 40 && !doneSeen; i++) begin
         @(negedge clk);
         if (stallMem) stallCnt++;
         if (busReq) begin
            if (reqCnt == 0) begin
               addrSeen = busAddr; wdSeen = busWData; weSeen = busWe; firstReqCyc = cyc;
            end else if (busAddr !== addrSeen || busWData !== wdSeen || busWe !== weSeen) begin
               stable = 1'b0;
            end
            lastReqCyc = cyc;
            busAck   = (reqCnt == ackAt);
            busRData = busAck ? rdDat : ~rdDat;
            reqCnt++;
         end else begin
            busAck = 1'b0;
            if (reqCnt > 0) begin
               doneSeen = 1'b1; doneData = readData; doneStall = stallMem;
            end
         end
         @(posedge clk);
         #1;
      end
      memRead = 1'b0; memWrite = 1'b0; busAck = 1'b0;
   endtask

   int            sc, rc, fr, lr, fr2, lr2;
   logic          st, we, dn, ds, anyReq, anyStall;
   logic [AW-1:0] as;
   logic [DW-1:0] wds, dd;

   initial begin
      reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; busAck = 1'b0;
      address = '0; writeData = '0; busRData = '0;
      stepCycle();
      stepCycle();
      reset = 1'b0;
      @(negedge clk);
      checkEq("rst_readData", readData, 0);
      checkEq("rst_busReq", busReq, 0);
      checkEq("rst_busWe", busWe, 0);
      checkEq("rst_busAddr", busAddr, 0);
      checkEq("rst_busWData", busWData, 0);
      checkEq("rst_faults", {misalignedFault, timeoutFault}, 0);
      checkEq("rst_stall", stallMem, 0);
      stepCycle();

      // Read, ack on first ACCESS cycle
      runAccess(1, 0, 32'h10, 32'h0, 32'hCAFEF00D, 0, sc, rc, fr, lr, st, we, as, wds, dd, dn, ds);
      checkEq("rd_done", dn, 1);
      checkEq("rd_stall", sc, 2);
      checkEq("rd_req", rc, 1);
      checkEq("rd_addr", as, 32'h10);
      checkEq("rd_we", we, 0);
      checkEq("rd_data", dd, 32'hCAFEF00D);
      checkEq("rd_doneStall", ds, 0);

      // Write with 3 wait cycles
      runAccess(0, 1, 32'h24, 32'h12345678, 32'h0BADBEEF, 3, sc, rc, fr, lr, st, we, as, wds, dd, dn, ds);
      checkEq("wr_done", dn, 1);
      checkEq("wr_we", we, 1);
      checkEq("wr_addr", as, 32'h24);
      checkEq("wr_wdata", wds, 32'h12345678);
      checkEq("wr_stable", st, 1);
      checkEq("wr_req", rc, 4);
      checkEq("wr_stall", sc, 5);
      checkEq("wr_readData", dd, 32'hCAFEF00D);

      // Misaligned read
      memRead = 1'b1; address = 32'h13; anyReq = 1'b0; anyStall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         anyReq   = anyReq | busReq;
         anyStall = anyStall | stallMem;
         stepCycle();
      end
      memRead = 1'b0;
      @(negedge clk);
      checkEq("mis_noReq", anyReq, 0);
      checkEq("mis_noStall", anyStall, 0);
      checkEq("mis_fault", misalignedFault, 1);
      checkEq("mis_readData", readData, 32'hCAFEF00D);
      checkEq("mis_noTimeout", timeoutFault, 0);
      stepCycle();

      // Timeout on read
      runAccess(1, 0, 32'h80, 32'h0, 32'h11112222, -1, sc, rc, fr, lr, st, we, as, wds, dd, dn, ds);
      checkEq("to_done", dn, 1);
      checkEq("to_req", rc, TO);
      checkEq("to_stall", sc, TO + 1);
      checkEq("to_readData", dd, 0);
      checkEq("to_fault", timeoutFault, 1);
      @(negedge clk);
      checkEq("to_idleReq", busReq, 0);
      checkEq("to_idleStall", stallMem, 0);
      stepCycle();

      // Read and write both high -> write
      runAccess(1, 1, 32'h50, 32'hDEADBEEF, 32'h33334444, 0, sc, rc, fr, lr, st, we, as, wds, dd, dn, ds);
      checkEq("both_we", we, 1);
      checkEq("both_wdata", wds, 32'hDEADBEEF);
      checkEq("both_readData", dd, 0);

      // Back-to-back load then store
      runAccess(1, 0, 32'h30, 32'h0, 32'h5A5A1234, 1, sc, rc, fr, lr, st, we, as, wds, dd, dn, ds);
      checkEq("b2b_ldData", dd, 32'h5A5A1234);
      checkEq("b2b_ldStall", sc, 3);
      runAccess(0, 1, 32'h34, 32'h87654321, 32'h0, 0, sc, rc, fr2, lr2, st, we, as, wds, dd, dn, ds);
      checkEq("b2b_gap", fr2 - lr, 3);
      checkEq("b2b_stData", dd, 32'h5A5A1234);
      checkEq("b2b_misSticky", misalignedFault, 1);

      // Reset during ACCESS, then a late ack
      memRead = 1'b1; address = 32'h40; busRData = 32'h77777777;
      stepCycle();
      stepCycle();
      stepCycle();
      checkEq("rstmid_inAccess", busReq, 1);
      reset = 1'b1; memRead = 1'b0; busAck = 1'b1;
      stepCycle();
      checkEq("rstmid_req", busReq, 0);
      checkEq("rstmid_faults", {misalignedFault, timeoutFault}, 0);
      checkEq("rstmid_readData", readData, 0);
      reset = 1'b0;
      stepCycle();
      @(negedge clk);
      checkEq("late_req", busReq, 0);
      checkEq("late_stall", stallMem, 0);
      checkEq("late_readData", readData, 0);
      busAck = 1'b0;
      stepCycle();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
